// File: rtl/nec_bus_ctrl.sv
// rtl/nec_bus_ctrl.sv - NEC V30 AD bus demux turning CPU bus cycles into memory/IO port requests
module nec_bus_ctrl #(
    parameter int          TIMEOUT_CYC = 256,
    parameter logic [15:0] READ_FILL   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_rise,
    input  logic        cpu_fall,
    input  logic [19:0] nec_ad_in,
    output logic [15:0] nec_ad_out,
    output logic        nec_ad_dir,
    input  logic [2:0]  nec_bs,
    input  logic        nec_ube_n,
    output logic        nec_ready,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [19:0] req_addr,
    output logic [1:0]  req_be,
    output logic        req_write,
    output logic        req_io,
    output logic        req_fetch,
    output logic [15:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_rdata,
    output logic [15:0] timeout_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0] BS_PASSIVE = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_T1, S_WDAT, S_REQ, S_RWAIT, S_DATA, S_DONE} state_t;

    state_t        state, state_nx;
    logic [2:0]    bs_q, bs_prev;
    logic [TW-1:0] tmo;
    logic          bs_inta, bs_halt, bs_wr, bs_rd, drives_bus;
    logic          tmo_hit, take_rsp, take_fill, tmo_evt;

    always_comb begin
        bs_inta    = (bs_q == 3'b000);
        bs_halt    = (bs_q == 3'b011);
        bs_wr      = (bs_q == 3'b010) || (bs_q == 3'b110);
        bs_rd      = (bs_q == 3'b001) || (bs_q == 3'b100) || (bs_q == 3'b101);
        drives_bus = bs_rd || bs_inta;
        tmo_hit    = (tmo == TW'(TIMEOUT_CYC - 1));
        req_valid  = (state == S_REQ);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Completion takes priority over a timeout landing in the same clk.
    always_comb begin
        state_nx  = state;
        take_rsp  = 1'b0;
        take_fill = 1'b0;
        tmo_evt   = 1'b0;
        case (state)
            S_IDLE: if (cpu_rise && nec_bs != BS_PASSIVE && bs_prev == BS_PASSIVE) state_nx = S_T1;
            S_T1: if (cpu_fall) begin
                if (bs_halt) begin
                    take_fill = 1'b1;
                    state_nx  = S_DONE;
                end else if (bs_inta) state_nx = S_DATA;
                else if (bs_wr)       state_nx = S_WDAT;
                else                  state_nx = S_REQ;
            end
            S_WDAT: if (cpu_rise) state_nx = S_REQ;
            S_REQ: begin
                if (req_ready) begin
                    if (bs_wr) state_nx = S_DONE;
                    else if (rsp_valid) begin
                        take_rsp = 1'b1;
                        state_nx = S_DONE;
                    end else state_nx = S_RWAIT;
                end else if (tmo_hit) begin
                    tmo_evt   = 1'b1;
                    take_fill = !bs_wr;
                    state_nx  = S_DONE;
                end
            end
            S_RWAIT: begin
                if (rsp_valid) begin
                    take_rsp = 1'b1;
                    state_nx = S_DONE;
                end else if (tmo_hit) begin
                    tmo_evt   = 1'b1;
                    take_fill = 1'b1;
                    state_nx  = S_DONE;
                end
            end
            S_DATA: begin
                take_fill = 1'b1;
                state_nx  = S_DONE;
            end
            S_DONE: if (cpu_rise && nec_bs == BS_PASSIVE) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bs_q        <= BS_PASSIVE;
            bs_prev     <= BS_PASSIVE;
            tmo         <= '0;
            nec_ad_out  <= '0;
            nec_ad_dir  <= 1'b0;
            nec_ready   <= 1'b1;
            req_addr    <= '0;
            req_be      <= '0;
            req_write   <= 1'b0;
            req_io      <= 1'b0;
            req_fetch   <= 1'b0;
            req_wdata   <= '0;
            timeout_cnt <= '0;
        end else begin
            if (cpu_rise) bs_prev <= nec_bs;
            if (state == S_IDLE && state_nx == S_T1) begin
                bs_q      <= nec_bs;
                nec_ready <= (nec_bs == 3'b011);
            end
            if (state == S_T1 && cpu_fall) begin
                req_addr  <= nec_ad_in;
                req_be    <= {~nec_ube_n, ~nec_ad_in[0]};
                req_write <= bs_wr;
                req_io    <= (bs_q == 3'b001) || (bs_q == 3'b010);
                req_fetch <= (bs_q == 3'b100);
            end
            if (state == S_WDAT && cpu_rise) req_wdata <= nec_ad_in[15:0];
            if (take_rsp)       nec_ad_out <= rsp_rdata;
            else if (take_fill) nec_ad_out <= READ_FILL;
            if (state != S_DONE && state_nx == S_DONE) nec_ready <= 1'b1;
            if (state != S_REQ && state_nx == S_REQ)         tmo <= '0;
            else if (state == S_REQ || state == S_RWAIT)     tmo <= tmo + 1'b1;
            if (tmo_evt && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
            // The CPU releases AD at T2, so the bus is only driven from the rise after T1.
            if (state == S_DONE && cpu_rise && nec_bs == BS_PASSIVE) nec_ad_dir <= 1'b0;
            else if (cpu_rise && drives_bus &&
                     (state == S_REQ || state == S_RWAIT || state == S_DATA || state == S_DONE))
                nec_ad_dir <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nec_bus_ctrl.sv
// tb/tb_nec_bus_ctrl.sv - randomized self-checking bench for nec_bus_ctrl
module tb_nec_bus_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0, cpu_rise = 1'b0, cpu_fall = 1'b0;
    logic [19:0] nec_ad_in = '0;
    logic [15:0] nec_ad_out;
    logic        nec_ad_dir;
    logic [2:0]  nec_bs = 3'b111;
    logic        nec_ube_n = 1'b1;
    logic        nec_ready, req_valid;
    logic        req_ready = 1'b0;
    logic [19:0] req_addr;
    logic [1:0]  req_be;
    logic        req_write, req_io, req_fetch;
    logic [15:0] req_wdata;
    logic        rsp_valid = 1'b0;
    logic [15:0] rsp_rdata = '0;
    logic [15:0] timeout_cnt;

    nec_bus_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cpu_rise(cpu_rise), .cpu_fall(cpu_fall),
        .nec_ad_in(nec_ad_in), .nec_ad_out(nec_ad_out), .nec_ad_dir(nec_ad_dir),
        .nec_bs(nec_bs), .nec_ube_n(nec_ube_n), .nec_ready(nec_ready),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_be(req_be),
        .req_write(req_write), .req_io(req_io), .req_fetch(req_fetch), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    int          be_mode = 0, be_ack = 0, be_rsp = 0, hs_cnt = 0;
    logic [15:0] be_rdata = '0, exp_tmo = '0;
    logic [19:0] snap_addr;
    logic [1:0]  snap_be;
    logic        snap_write, snap_io, snap_fetch;
    logic [15:0] snap_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rise();
        cpu_rise = 1'b1; @(negedge clk); cpu_rise = 1'b0; @(negedge clk);
    endtask

    task automatic fall();
        cpu_fall = 1'b1; @(negedge clk); cpu_fall = 1'b0; @(negedge clk);
    endtask

    // Back end: mode 0 answers normally, 1 accepts but never returns read data, 2 never accepts.
    initial begin
        forever begin
            @(negedge clk);
            req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 16'($urandom);
            if (req_valid && be_mode != 2) begin
                repeat (be_ack) @(negedge clk);
                {snap_addr, snap_be, snap_write, snap_io, snap_fetch} =
                    {req_addr, req_be, req_write, req_io, req_fetch};
                snap_wdata = req_wdata;
                req_ready  = 1'b1;
                if (!snap_write && be_mode == 0 && be_rsp == 0) begin
                    rsp_valid = 1'b1; rsp_rdata = be_rdata;
                end
                @(negedge clk);
                req_ready = 1'b0; rsp_valid = 1'b0;
                hs_cnt++;
                if (!snap_write && be_mode == 0 && be_rsp > 0) begin
                    repeat (be_rsp - 1) @(negedge clk);
                    rsp_valid = 1'b1; rsp_rdata = be_rdata;
                    @(negedge clk);
                    rsp_valid = 1'b0;
                end
            end
        end
    end

    task automatic bus_cycle(input logic [2:0] bs, input logic [19:0] addr, input logic ube,
                             input logic [15:0] wd, input logic [15:0] rd,
                             input int ack, input int rsp, input int mode);
        bit          is_req = !(bs == 3'b000 || bs == 3'b011);
        bit          is_wr  = (bs == 3'b010 || bs == 3'b110);
        bit          drives = !is_wr && bs != 3'b011;
        bit          seen   = 1'b0;
        int          hs0    = hs_cnt;
        logic [15:0] exp_data;
        be_mode = mode; be_ack = ack; be_rsp = rsp; be_rdata = rd;
        exp_data = (is_req && mode == 0) ? rd : 16'hFFFF;
        if (is_req && (mode == 2 || (mode == 1 && !is_wr)) && exp_tmo != 16'hFFFF)
            exp_tmo = exp_tmo + 16'd1;
        nec_bs = bs; nec_ad_in = addr; nec_ube_n = ube;
        rise();
        chk("t1_ready", nec_ready, bs == 3'b011);
        fall();
        nec_ad_in = is_wr ? {4'h0, wd} : 20'($urandom);
        for (int i = 0; i < 120 && !seen; i++) begin
            rise(); fall();
            seen = nec_ready;
        end
        chk("ready_seen", seen, 1'b1);
        chk("ad_dir", nec_ad_dir, drives);
        if (!is_wr) chk("ad_out", nec_ad_out, exp_data);
        nec_bs = 3'b111;
        rise();
        chk("t4_dir", nec_ad_dir, 1'b0);
        chk("timeout_cnt", timeout_cnt, exp_tmo);
        chk("handshakes", hs_cnt - hs0, (is_req && mode != 2));
        if (is_req && mode != 2) begin
            chk("req_fields", {snap_addr, snap_be, snap_write, snap_io, snap_fetch},
                {addr, ~ube, ~addr[0], is_wr, (bs == 3'b001 || bs == 3'b010), bs == 3'b100});
            if (is_wr) chk("req_wdata", snap_wdata, wd);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", nec_ready, 1'b1);
        chk("rst_dir", nec_ad_dir, 1'b0);
        chk("rst_valid", req_valid, 1'b0);
        chk("rst_ad_out", nec_ad_out, 16'h0);
        chk("rst_tmo", timeout_cnt, 16'h0);
        reset_n = 1'b1;
        @(negedge clk);
        rise();

        bus_cycle(3'b101, 20'h12345, 1'b0, 16'h0, 16'hBEEF, 0, 5, 0);
        bus_cycle(3'b110, 20'h00400, 1'b0, 16'hA55A, 16'h0, 1, 0, 0);
        bus_cycle(3'b010, 20'h00060, 1'b1, 16'h0033, 16'h0, 0, 0, 0);
        bus_cycle(3'b010, 20'h00061, 1'b1, 16'h3300, 16'h0, 0, 0, 0);
        bus_cycle(3'b101, 20'h0F00E, 1'b0, 16'h0, 16'h1234, 0, 0, 2);
        for (int i = 0; i < 4; i++)
            bus_cycle(3'b100, 20'h08000 + 20'(2 * i), 1'b0, 16'h0, 16'(16'h9000 + i), 0, 1, 0);
        bus_cycle(3'b000, 20'h00000, 1'b0, 16'h0, 16'h0, 0, 0, 0);
        bus_cycle(3'b011, 20'h00000, 1'b0, 16'h0, 16'h0, 0, 0, 0);
        bus_cycle(3'b001, 20'h000F8, 1'b1, 16'h0, 16'h5678, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            int r = int'($urandom_range(0, 9));
            bus_cycle(3'($urandom_range(0, 6)), 20'($urandom), 1'($urandom), 16'($urandom),
                      16'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      (r == 0) ? 1 : (r == 1) ? 2 : 0);
        end

        be_mode = 1; be_ack = 0;
        nec_bs = 3'b101; nec_ad_in = 20'h0ABCD; nec_ube_n = 1'b0;
        rise(); fall(); rise();
        chk("rwait_dir", nec_ad_dir, 1'b1);
        chk("rwait_valid", req_valid, 1'b0);
        chk("rwait_ready", nec_ready, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", req_valid, 1'b0);
        chk("mid_rst_ready", nec_ready, 1'b1);
        chk("mid_rst_dir", nec_ad_dir, 1'b0);
        @(negedge clk);
        reset_n = 1'b1; exp_tmo = '0;
        nec_bs = 3'b111;
        rise();
        bus_cycle(3'b101, 20'h0ABCD, 1'b0, 16'h0, 16'hC0DE, 0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
